vga_timing_gen: RTL and testbench

//  Parametrised VGA/raster timing generator: next generation of the fixed 640x480 sync block.

---
 rtl/vga_timing_gen_pkg.sv | 37 +++
 rtl/vga_pix_div.sv | 26 ++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing presets and sync-window helper for the VGA timing generator
// and the pixel generators that need the same screen bounds.
package vga_timing_gen_pkg;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_DISP = 640;
    localparam int VGA640_H_FP   = 16;
    localparam int VGA640_H_SYNC = 96;
    localparam int VGA640_H_BP   = 48;
    localparam int VGA640_V_DISP = 480;
    localparam int VGA640_V_FP   = 10;
    localparam int VGA640_V_SYNC = 2;
    localparam int VGA640_V_BP   = 33;
    localparam logic VGA640_H_POL = POL_LOW;
    localparam logic VGA640_V_POL = POL_LOW;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA800_H_DISP = 800;
    localparam int SVGA800_H_FP   = 40;
    localparam int SVGA800_H_SYNC = 128;
    localparam int SVGA800_H_BP   = 88;
    localparam int SVGA800_V_DISP = 600;
    localparam int SVGA800_V_FP   = 1;
    localparam int SVGA800_V_SYNC = 4;
    localparam int SVGA800_V_BP   = 23;
    localparam logic SVGA800_H_POL = POL_HIGH;
    localparam logic SVGA800_V_POL = POL_HIGH;

    // True when pos lies in the sync window that starts after display + front porch.
    function automatic logic in_sync(input int pos, input int disp, input int fp, input int width);
        return (pos >= disp + fp) && (pos <= disp + fp + width - 1);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate enable: one-clk p_tick every PIX_DIV enabled clocks.
module vga_pix_div #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic p_tick
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign p_tick = en & ~reset & (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters advance on the pixel tick, and every
// output is registered from the counters so sync, video_on and coordinates stay aligned.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_DISP  = 640,
    parameter int   H_FP    = 16,
    parameter int   H_SYNC  = 96,
    parameter int   H_BP    = 48,
    parameter int   V_DISP  = 480,
    parameter int   V_FP    = 10,
    parameter int   V_SYNC  = 2,
    parameter int   V_BP    = 33,
    parameter logic H_POL   = 1'b0,
    parameter logic V_POL   = 1'b0,
    parameter int   PIX_DIV = 2,
    parameter int   CNT_W   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             p_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (PIX_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
    if ((longint'(H_TOTAL) > (longint'(1) << CNT_W)) ||
        (longint'(V_TOTAL) > (longint'(1) << CNT_W))) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_act;
    logic             vs_act;
    logic             disp_act;
    logic             wrap_seen;

    vga_pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .p_tick (p_tick)
    );

    always_comb begin
        hs_act   = in_sync(int'(h_cnt), H_DISP, H_FP, H_SYNC);
        vs_act   = in_sync(int'(v_cnt), V_DISP, V_FP, V_SYNC);
        disp_act = (h_cnt < CNT_W'(H_DISP)) && (v_cnt < CNT_W'(V_DISP));
        // Counter is at column 0 while the visible column is not: first clk after a wrap.
        wrap_seen = (h_cnt == '0) && (pixel_x != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b1;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            if (p_tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            video_on    <= disp_act;
            hsync       <= hs_act ? H_POL : ~H_POL;
            vsync       <= vs_act ? V_POL : ~V_POL;
            line_start  <= wrap_seen;
            frame_start <= wrap_seen && (v_cnt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny active-high instance
// share stimulus and are compared every clk against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int B_HD = 640, B_HF = 16, B_HW = 96, B_HB = 48;
    localparam int B_VD = 480, B_VF = 10, B_VW = 2,  B_VB = 33;
    localparam int B_D  = 2;
    localparam int S_HD = 8, S_HF = 2, S_HW = 3, S_HB = 2;
    localparam int S_VD = 5, S_VF = 1, S_VW = 2, S_VB = 1;
    localparam int S_D  = 1;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
        bit ls;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;

    logic       b_tick, b_hs, b_vs, b_vo, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       s_tick, s_hs, s_vs, s_vo, s_ls, s_fs;
    logic [3:0] s_x, s_y;

    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    longint n_en = 0;
    exp_t   eb;
    exp_t   es;

    always #5 clk = ~clk;

    vga_timing_gen dut_big (
        .clk(clk), .reset(reset), .en(en), .p_tick(b_tick),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
        .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .H_DISP(S_HD), .H_FP(S_HF), .H_SYNC(S_HW), .H_BP(S_HB),
        .V_DISP(S_VD), .V_FP(S_VF), .V_SYNC(S_VW), .V_BP(S_VB),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(S_D), .CNT_W(4)
    ) dut_small (
        .clk(clk), .reset(reset), .en(en), .p_tick(s_tick),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
        .pixel_x(s_x), .pixel_y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t reset_val(input bit hp, input bit vp);
        exp_t e;
        e.x = 0; e.y = 0; e.hs = !hp; e.vs = !vp; e.vo = 1'b1; e.ls = 1'b0; e.fs = 1'b0;
        return e;
    endfunction

    // Display of an edge after n enabled clocks since reset: pixel index = ticks mod frame size.
    function automatic exp_t calc(input longint n, input int d,
                                  input int hd, input int hf, input int hw, input int hb,
                                  input int vd, input int vf, input int vw, input int vb,
                                  input bit hp, input bit vp);
        exp_t   e;
        longint t, p;
        int     ht, vt;
        ht = hd + hf + hw + hb;
        vt = vd + vf + vw + vb;
        t = n / d;
        p = t % (ht * vt);
        e.x  = int'(p % ht);
        e.y  = int'(p / ht);
        e.hs = (e.x >= hd + hf && e.x <= hd + hf + hw - 1) ? hp : !hp;
        e.vs = (e.y >= vd + vf && e.y <= vd + vf + vw - 1) ? vp : !vp;
        e.vo = (e.x < hd) && (e.y < vd);
        e.ls = (e.x == 0) && (t > 0) && (n % d == 0);
        e.fs = e.ls && (e.y == 0);
        return e;
    endfunction

    task automatic compare_all();
        check("big_x", b_x, eb.x);    check("big_y", b_y, eb.y);
        check("big_hsync", b_hs, eb.hs); check("big_vsync", b_vs, eb.vs);
        check("big_video_on", b_vo, eb.vo);
        check("big_line_start", b_ls, eb.ls); check("big_frame_start", b_fs, eb.fs);
        check("small_x", s_x, es.x);  check("small_y", s_y, es.y);
        check("small_hsync", s_hs, es.hs); check("small_vsync", s_vs, es.vs);
        check("small_video_on", s_vo, es.vo);
        check("small_line_start", s_ls, es.ls); check("small_frame_start", s_fs, es.fs);
    endtask

    // One clk: drive inputs, check p_tick mid-cycle, then check registered outputs after the edge.
    task automatic step(input bit r, input bit e);
        reset = r;
        en = e;
        @(negedge clk);
        check("big_p_tick", b_tick, e && !r && (n_en % B_D == B_D - 1));
        check("small_p_tick", s_tick, e && !r && (n_en % S_D == S_D - 1));
        @(posedge clk);
        #1;
        if (r) begin
            eb = reset_val(1'b0, 1'b0);
            es = reset_val(1'b1, 1'b1);
            n_en = 0;
        end else if (e) begin
            eb = calc(n_en, B_D, B_HD, B_HF, B_HW, B_HB, B_VD, B_VF, B_VW, B_VB, 1'b0, 1'b0);
            es = calc(n_en, S_D, S_HD, S_HF, S_HW, S_HB, S_VD, S_VF, S_VW, S_VB, 1'b1, 1'b1);
            n_en++;
        end else begin
            eb.ls = 1'b0; eb.fs = 1'b0;
            es.ls = 1'b0; es.fs = 1'b0;
        end
        compare_all();
        cyc++;
    endtask

    int fall_c = -1;
    int ls_c = -1;
    int n_ls = 0;
    int s_fs_n = 0;
    int s_ls_n = 0;
    bit prev_hs = 1'b1;

    initial begin
        eb = reset_val(1'b0, 1'b0);
        es = reset_val(1'b1, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

        // Clean run: line-level timing of the default instance, frame counts of the small one.
        for (int i = 0; i < 3400; i++) begin
            step(1'b0, 1'b1);
            if (prev_hs && !b_hs) fall_c = cyc;
            if (!prev_hs && b_hs && fall_c >= 0) check("hsync_low_clks", cyc - fall_c, 192);
            prev_hs = b_hs;
            if (b_ls) begin
                if (ls_c >= 0) check("line_period_clks", cyc - ls_c, 1600);
                ls_c = cyc;
                n_ls++;
            end
            if (i >= 500 && i < 770) begin
                s_fs_n += int'(s_fs);
                s_ls_n += int'(s_ls);
            end
        end
        check("line_starts_seen", n_ls, 2);
        check("small_frame_starts", s_fs_n, 2);
        check("small_line_starts", s_ls_n, 18);

        // Pause mid-line at x=300 for 37 clks.
        for (int i = 0; i < 2000 && b_x != 10'd300; i++) step(1'b0, 1'b1);
        check("reach_x300", b_x, 300);
        for (int i = 0; i < 37; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);

        // Random enables and occasional mid-frame resets.
        for (int i = 0; i < 30000; i++) begin
            step($urandom_range(0, 1999) == 0, $urandom_range(0, 7) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
